emc_xmem_responder: RTL

External program-memory responder for the EMC08 core's code-fetch bus. It watches PSEN_B together with the address the core presents on P0/P2, and fetches the byte from a synchronous memory port. It drives that byte back onto the P0 data lines, with an optional one-byte sequential prefetch buffer. It sits outside the core, on the board or wrapper side, and is the memory end of the fetch protocol the core initiates.

---
 rtl/emc_xmem_responder_if.sv | 28 ++
 rtl/emc_xmem_responder.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/emc_xmem_responder_if.sv
// Code-fetch bus between the EMC08 core pins, the responder and its synchronous memory port.
// The responder takes the slave view; the core/memory side (or a bench) takes the master view.
interface emc_xmem_responder_if #(
  parameter int ADDR_W = 16
);
  logic              PSEN_B;
  logic              EA_B;
  logic [7:0]        P0_IN;
  logic [7:0]        P2_IN;
  logic [7:0]        P0_OUT;
  logic              P0_OE;
  logic              MEM_REQ;
  logic [ADDR_W-1:0] MEM_ADDR;
  logic [7:0]        MEM_RDATA;
  logic              MEM_RVALID;
  logic [15:0]       FETCH_CNT;
  logic              LATE_ERR;

  modport slave (
    input  PSEN_B, EA_B, P0_IN, P2_IN, MEM_RDATA, MEM_RVALID,
    output P0_OUT, P0_OE, MEM_REQ, MEM_ADDR, FETCH_CNT, LATE_ERR
  );

  modport master (
    output PSEN_B, EA_B, P0_IN, P2_IN, MEM_RDATA, MEM_RVALID,
    input  P0_OUT, P0_OE, MEM_REQ, MEM_ADDR, FETCH_CNT, LATE_ERR
  );
endinterface

// File: rtl/emc_xmem_responder.sv
// External program-memory responder: answers PSEN_B code fetches from a synchronous memory
// port, with an optional one-byte sequential prefetch buffer. All outputs are registered.
module emc_xmem_responder #(
  parameter int          ADDR_W       = 16,
  parameter int unsigned INT_ROM_SIZE = 4096,
  parameter int          PREFETCH     = 1
) (
  input logic                 CLOCK,
  input logic                 RESET,
  emc_xmem_responder_if.slave bus
);

  localparam bit PF_EN = (PREFETCH != 0);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DRAIN,
    ST_DRIVE,
    ST_PFETCH,
    ST_SKIP
  } state_e;

  state_e            state_q,     state_d;
  logic              psen_q,      psen_d;
  logic [ADDR_W-1:0] addr_q,      addr_d;
  logic              pend_q,      pend_d;
  logic [7:0]        p0_out_q,    p0_out_d;
  logic              p0_oe_q,     p0_oe_d;
  logic              mem_req_q,   mem_req_d;
  logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
  logic [15:0]       fetch_cnt_q, fetch_cnt_d;
  logic              late_err_q,  late_err_d;
  logic              pf_valid_q,  pf_valid_d;
  logic [ADDR_W-1:0] pf_addr_q,   pf_addr_d;
  logic [7:0]        pf_data_q,   pf_data_d;

  logic              start;
  logic              serviced;
  logic              do_start;
  logic              eff_valid;
  logic [ADDR_W-1:0] eff_addr;
  logic [7:0]        eff_data;

  assign start    = psen_q & ~bus.PSEN_B;
  assign serviced = ~bus.EA_B | (32'(addr_q) >= INT_ROM_SIZE);

  always_comb begin
    // NOTE: every _d starts from a hold/default value so no branch can leave a latch behind.
    state_d     = state_q;
    psen_d      = bus.PSEN_B;
    addr_d      = bus.PSEN_B ? ADDR_W'({bus.P2_IN, bus.P0_IN}) : addr_q;
    pend_d      = 1'b0;
    p0_out_d    = p0_out_q;
    p0_oe_d     = p0_oe_q;
    mem_req_d   = 1'b0;
    mem_addr_d  = mem_addr_q;
    fetch_cnt_d = fetch_cnt_q;
    late_err_d  = late_err_q;
    pf_valid_d  = pf_valid_q;
    pf_addr_d   = pf_addr_q;
    pf_data_d   = pf_data_q;
    do_start    = 1'b0;
    eff_valid   = pf_valid_q;
    eff_addr    = pf_addr_q;
    eff_data    = pf_data_q;

    unique case (state_q)
      ST_IDLE: begin
        do_start = start;
      end

      ST_WAIT: begin
        if (bus.PSEN_B) begin
          late_err_d = 1'b1;
          state_d    = bus.MEM_RVALID ? ST_IDLE : ST_DRAIN;
        end else if (bus.MEM_RVALID) begin
          state_d  = ST_DRIVE;
          p0_out_d = bus.MEM_RDATA;
          p0_oe_d  = 1'b1;
        end
      end

      // A fetch that starts while the abandoned response is still in flight waits for it.
      ST_DRAIN: begin
        if (bus.MEM_RVALID) begin
          state_d  = ST_IDLE;
          do_start = (pend_q | start) & ~bus.PSEN_B;
        end else begin
          pend_d = (pend_q | start) & ~bus.PSEN_B;
        end
      end

      ST_DRIVE: begin
        if (bus.PSEN_B) begin
          p0_oe_d     = 1'b0;
          fetch_cnt_d = fetch_cnt_q + 16'd1;
          if (PF_EN) begin
            state_d    = ST_PFETCH;
            mem_req_d  = 1'b1;
            mem_addr_d = addr_q + ADDR_W'(1);
          end else begin
            state_d = ST_IDLE;
          end
        end
      end

      // mem_addr_q still holds the prefetch address, so it doubles as the tag to store.
      ST_PFETCH: begin
        if (bus.MEM_RVALID) begin
          state_d    = ST_IDLE;
          pf_valid_d = 1'b1;
          pf_addr_d  = mem_addr_q;
          pf_data_d  = bus.MEM_RDATA;
          eff_valid  = 1'b1;
          eff_addr   = mem_addr_q;
          eff_data   = bus.MEM_RDATA;
          do_start   = (pend_q | start) & ~bus.PSEN_B;
        end else begin
          pend_d = (pend_q | start) & ~bus.PSEN_B;
        end
      end

      ST_SKIP: begin
        if (bus.PSEN_B) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Start decision shared by IDLE and the deferred starts from DRAIN/PFETCH.
    if (do_start) begin
      if (!serviced) begin
        state_d = ST_SKIP;
      end else if (PF_EN && eff_valid && (eff_addr == addr_q)) begin
        state_d    = ST_DRIVE;
        p0_out_d   = eff_data;
        p0_oe_d    = 1'b1;
        pf_valid_d = 1'b0;
      end else begin
        state_d    = ST_WAIT;
        mem_req_d  = 1'b1;
        mem_addr_d = addr_q;
        pf_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge CLOCK) begin
    // NOTE: non-blocking assignments so every flop samples the pre-edge value of its _d.
    if (RESET) begin
      state_q     <= ST_IDLE;
      psen_q      <= 1'b1;
      addr_q      <= '0;
      pend_q      <= 1'b0;
      p0_out_q    <= 8'h00;
      p0_oe_q     <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
      fetch_cnt_q <= 16'h0000;
      late_err_q  <= 1'b0;
      pf_valid_q  <= 1'b0;
      pf_addr_q   <= '0;
      pf_data_q   <= 8'h00;
    end else begin
      state_q     <= state_d;
      psen_q      <= psen_d;
      addr_q      <= addr_d;
      pend_q      <= pend_d;
      p0_out_q    <= p0_out_d;
      p0_oe_q     <= p0_oe_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
      fetch_cnt_q <= fetch_cnt_d;
      late_err_q  <= late_err_d;
      pf_valid_q  <= pf_valid_d;
      pf_addr_q   <= pf_addr_d;
      pf_data_q   <= pf_data_d;
    end
  end

  assign bus.P0_OUT    = p0_out_q;
  assign bus.P0_OE     = p0_oe_q;
  assign bus.MEM_REQ   = mem_req_q;
  assign bus.MEM_ADDR  = mem_addr_q;
  assign bus.FETCH_CNT = fetch_cnt_q;
  assign bus.LATE_ERR  = late_err_q;

endmodule
